// File: rtl/cache_types_pkg.sv
// cache_types_pkg: controller state encoding and tree-PLRU victim/update helpers (sized for up to 8 ways)
package cache_types_pkg;
  typedef enum logic [1:0] {COMPARE, WRITE_BACK, ALLOCATE} state_t;
  // Walk the heap-ordered tree from the root; a node bit of 1 sends the search right
  function automatic logic [2:0] plru_victim(input logic [6:0] bits, input int lvls);
    int node;
    node = 1;
    for (int l = 0; l < 3; l++)
      if (l < lvls) node = 2 * node + int'(bits[node-1]);
    return 3'(node - (1 << lvls));
  endfunction
  // Every node on the accessed way's path is flipped to point at the other subtree
  function automatic logic [6:0] plru_update(input logic [6:0] bits, input int lvls, input logic [2:0] way);
    logic [6:0] b;
    logic d;
    int node;
    b = bits;
    node = 1;
    for (int l = 0; l < 3; l++)
      if (l < lvls) begin
        d = way[lvls-1-l];
        b[node-1] = ~d;
        node = 2 * node + int'(d);
      end
    return b;
  endfunction
endpackage

// File: rtl/assoc_cache_ctrl_if.sv
// assoc_cache_ctrl_if: CPU request, tag-array status, pmem handshake and array write-control bundle
interface assoc_cache_ctrl_if #(parameter int WAYS = 4, parameter int SETS = 16);
  localparam int IW = $clog2(SETS);
  logic mem_read, mem_write;
  logic [IW-1:0] set_idx;
  logic [WAYS-1:0] hit_vec, valid_vec, dirty_vec;
  logic pmem_resp;
  logic mem_resp, pmem_read, pmem_write;
  logic [WAYS-1:0] way_sel;
  logic data_we, tag_we, valid_we, dirty_we, dirty_in, data_src;
  modport master (
    output mem_read, mem_write, set_idx, hit_vec, valid_vec, dirty_vec, pmem_resp,
    input mem_resp, pmem_read, pmem_write, way_sel, data_we, tag_we, valid_we, dirty_we, dirty_in, data_src
  );
  modport slave (
    input mem_read, mem_write, set_idx, hit_vec, valid_vec, dirty_vec, pmem_resp,
    output mem_resp, pmem_read, pmem_write, way_sel, data_we, tag_we, valid_we, dirty_we, dirty_in, data_src
  );
endinterface

// File: rtl/plru_tree.sv
// plru_tree: per-set tree-PLRU bits, victim lookup for idx and update on accessed way
module plru_tree
  import cache_types_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 16,
  localparam int IW = $clog2(SETS),
  localparam int WW = $clog2(WAYS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] idx,
  input  logic [WW-1:0] way,
  input  logic          upd,
  output logic [WW-1:0] victim
);
  logic [SETS-1:0][WAYS-2:0] tree;
  logic [6:0] cur;
  logic [WAYS-2:0] nxt;
  assign cur = 7'(tree[idx]);
  assign nxt = (WAYS-1)'(plru_update(cur, WW, 3'(way)));
  assign victim = WW'(plru_victim(cur, WW));
  // Tree bits of the addressed set move away from the way just accessed
  always_ff @(posedge clk or posedge rst)
    if (rst) tree <= '0;
    else if (upd) tree[idx] <= nxt;
endmodule

// File: rtl/assoc_cache_ctrl.sv
// assoc_cache_ctrl: set-associative cache controller (zero-wait hits, writeback, allocate); CACHE_CTRL_PERF_EN adds hit/miss/writeback counters
module assoc_cache_ctrl
  import cache_types_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 16
) (
  input logic clk,
  input logic rst,
  assoc_cache_ctrl_if.slave bus
`ifdef CACHE_CTRL_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
  output logic [31:0] wb_cnt
`endif
);
  localparam int WW = $clog2(WAYS);
  state_t state;
  logic [WW-1:0] victim_q, hit_way, inv_way, plru_way, new_victim;
  logic req, hit_acc, miss, fill, wr_hit, dirty_victim;
  // Lowest-index hit way and lowest-index invalid way
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (bus.hit_vec[i]) hit_way = WW'(i);
      if (!bus.valid_vec[i]) inv_way = WW'(i);
    end
  end
  assign new_victim = &bus.valid_vec ? plru_way : inv_way;
  assign dirty_victim = bus.dirty_vec[new_victim];
  assign req = bus.mem_read | bus.mem_write;
  assign hit_acc = !rst && state == COMPARE && req && |bus.hit_vec;
  assign miss = !rst && state == COMPARE && req && ~|bus.hit_vec;
  assign wr_hit = hit_acc && bus.mem_write;
  assign fill = bus.pmem_read && bus.pmem_resp;
  assign bus.mem_resp = hit_acc;
  assign bus.pmem_write = !rst && state == WRITE_BACK;
  assign bus.pmem_read = !rst && state == ALLOCATE;
  assign bus.data_we = fill | wr_hit;
  assign bus.dirty_we = fill | wr_hit;
  assign bus.tag_we = fill;
  assign bus.valid_we = fill;
  assign bus.dirty_in = wr_hit;
  assign bus.data_src = bus.pmem_read;
  assign bus.way_sel = (bus.pmem_read | bus.pmem_write) ? WAYS'(1) << victim_q :
                       hit_acc ? WAYS'(1) << hit_way :
                       miss ? WAYS'(1) << new_victim : '0;
  plru_tree #(.WAYS(WAYS), .SETS(SETS)) u_plru (
    .clk(clk),
    .rst(rst),
    .idx(bus.set_idx),
    .way(hit_way),
    .upd(hit_acc),
    .victim(plru_way)
  );
  // Miss handling FSM; the victim is captured on the miss cycle and held until COMPARE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= COMPARE;
      victim_q <= '0;
    end else
      case (state)
        COMPARE:
          if (miss) begin
            victim_q <= new_victim;
            state <= dirty_victim ? WRITE_BACK : ALLOCATE;
          end
        WRITE_BACK: if (bus.pmem_resp) state <= ALLOCATE;
        ALLOCATE: if (bus.pmem_resp) state <= COMPARE;
        default: state <= COMPARE;
      endcase
`ifdef CACHE_CTRL_PERF_EN
  // Saturating event counters; a writeback is counted on the dirty miss that starts it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hit_cnt <= '0;
      miss_cnt <= '0;
      wb_cnt <= '0;
    end else begin
      if (hit_acc && ~&hit_cnt) hit_cnt <= hit_cnt + 32'd1;
      if (miss && ~&miss_cnt) miss_cnt <= miss_cnt + 32'd1;
      if (miss && dirty_victim && ~&wb_cnt) wb_cnt <= wb_cnt + 32'd1;
    end
`endif
endmodule
